// File: rtl/coin_pkg.sv
// coin_pkg: shared coin codes, code-to-solenoid decode and hopper states
package coin_pkg;

   localparam logic [2:0] COIN_NONE    = 3'd0;
   localparam logic [2:0] COIN_PENNY   = 3'd1;
   localparam logic [2:0] COIN_NICKEL  = 3'd2;
   localparam logic [2:0] COIN_DIME    = 3'd3;
   localparam logic [2:0] COIN_QUARTER = 3'd4;
   localparam logic [2:0] COIN_HALF    = 3'd5;
   localparam logic [2:0] COIN_DOLLAR  = 3'd6;

   typedef enum logic [1:0] {HOP_IDLE, HOP_PULSE, HOP_WAIT, HOP_FAULT} hop_state_t;

   function automatic logic [5:0] coin_onehot(input logic [2:0] code);
      return (code == COIN_NONE || code == 3'd7) ? 6'd0 : 6'd1 << (code - COIN_PENNY);
   endfunction

endpackage

// File: rtl/sensor_sync_edge.sv
// sensor_sync_edge: two-flop synchronizer with a registered rising-edge pulse
module sensor_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic sensor,
   output logic rise
);

   logic [2:0] sh;

   // shift the raw sensor through two sync flops plus one history flop, flag 0->1
   always_ff @(posedge clock) begin
      if (!reset) begin
         sh   <= '0;
         rise <= 1'b0;
      end else begin
         sh   <= {sh[1:0], sensor};
         rise <= sh[1] & ~sh[2];
      end
   end

endmodule

// File: rtl/coin_hopper_ctrl.sv
// coin_hopper_ctrl: one-coin-at-a-time hopper solenoid sequencer with inventory and jam fault
module coin_hopper_ctrl
   import coin_pkg::*;
#(
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MAX_RETRY      = 2,
   parameter int INV_W          = 8,
   parameter int INV_INIT       = 50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [2:0] coin_to_return,
   output logic       coin_ready,
   input  logic       coin_sensor,
   input  logic       refill,
   input  logic [2:0] refill_sel,
   input  logic       fault_clear,
   output logic [5:0] eject,
   output logic       dispensed,
   output logic       underflow,
   output logic [5:0] empty,
   output logic       fault
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   hop_state_t       state, state_nxt;
   logic [5:0]       sel, sel_nxt;
   logic [PW-1:0]    pcnt, pcnt_nxt;
   logic [TW-1:0]    tcnt, tcnt_nxt;
   logic [RW-1:0]    retry, retry_nxt;
   logic [INV_W-1:0] inv [6];
   logic [5:0]       req_oh, ref_oh, inv_zero;
   logic             rise, done, under;

   assign req_oh = coin_onehot(coin_to_return);
   assign ref_oh = refill ? coin_onehot(refill_sel) : '0;

   sensor_sync_edge u_sync (
      .clock  (clock),
      .reset  (reset),
      .sensor (coin_sensor),
      .rise   (rise)
   );

   // per-denomination zero detect; the decision uses the live count, the empty port lags a cycle
   always_comb begin
      inv_zero = '0;
      for (int i = 0; i < 6; i++) inv_zero[i] = inv[i] == '0;
   end

   // next state: accept/discard in IDLE, timed pulse, sensor wait with retries, sticky fault
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      pcnt_nxt  = pcnt;
      tcnt_nxt  = tcnt;
      retry_nxt = retry;
      done      = 1'b0;
      under     = 1'b0;
      case (state)
         HOP_IDLE:
            if (coin_valid) begin
               if (|(req_oh & inv_zero)) under = 1'b1;
               else if (|req_oh) begin
                  state_nxt = HOP_PULSE;
                  sel_nxt   = req_oh;
                  pcnt_nxt  = '0;
                  retry_nxt = '0;
               end
            end
         HOP_PULSE:
            if (rise) begin
               state_nxt = HOP_IDLE;
               done      = 1'b1;
            end else if (pcnt == PW'(PULSE_CYCLES - 1)) begin
               state_nxt = HOP_WAIT;
               tcnt_nxt  = '0;
            end else pcnt_nxt = pcnt + 1'b1;
         HOP_WAIT:
            if (rise) begin
               state_nxt = HOP_IDLE;
               done      = 1'b1;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               if (retry < RW'(MAX_RETRY)) begin
                  state_nxt = HOP_PULSE;
                  retry_nxt = retry + 1'b1;
                  pcnt_nxt  = '0;
               end else state_nxt = HOP_FAULT;
            end else tcnt_nxt = tcnt + 1'b1;
         default:
            if (fault_clear) state_nxt = HOP_IDLE;
      endcase
   end

   // state and counters, with every output registered from the next-state view
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= HOP_IDLE;
         sel        <= '0;
         pcnt       <= '0;
         tcnt       <= '0;
         retry      <= '0;
         coin_ready <= 1'b1;
         eject      <= '0;
         dispensed  <= 1'b0;
         underflow  <= 1'b0;
         empty      <= '0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         sel        <= sel_nxt;
         pcnt       <= pcnt_nxt;
         tcnt       <= tcnt_nxt;
         retry      <= retry_nxt;
         coin_ready <= state_nxt == HOP_IDLE;
         eject      <= state_nxt == HOP_PULSE ? sel_nxt : '0;
         dispensed  <= done;
         underflow  <= under;
         empty      <= inv_zero;
         fault      <= state_nxt == HOP_FAULT;
      end
   end

   // inventory: refill reloads and beats a same-cycle decrement, counts saturate at zero
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 6; i++) inv[i] <= INV_W'(INV_INIT);
      end else begin
         for (int i = 0; i < 6; i++)
            if (ref_oh[i]) inv[i] <= INV_W'(INV_INIT);
            else if (done && sel[i] && !inv_zero[i]) inv[i] <= inv[i] - 1'b1;
      end
   end

endmodule

// File: doc/coin_hopper_ctrl.md
# coin_hopper_ctrl

Drives the six coin-hopper eject solenoids from the coin codes issued by `coin_dispenser`, one coin at a time. It is the receiving end of the `coin_to_return` interface. Each coin is held until the exit-chute sensor confirms it left the machine, or until retries are exhausted. It maintains per-denomination inventory counts and empty flags, and raises a sticky jam fault. It sits between `coin_dispenser` and the physical hopper in the change-return path.

## Interface
Parameters:
- `PULSE_CYCLES`, 4: solenoid on-time per attempt (≥1).
- `TIMEOUT_CYCLES`, 64: wait for sensor after pulse ends (≥4).
- `MAX_RETRY`, 2: re-pulses allowed before fault.
- `INV_W`, 8: inventory counter width.
- `INV_INIT`, 50: count loaded at reset/refill (must be nonzero, < 2^INV_W).

Ports (name, direction, width, meaning):
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; reset applies when low at a rising edge.
- `coin_valid` input 1: `coin_to_return` holds a request.
- `coin_to_return` input 3: 001 penny, 010 nickel, 011 dime, 100 quarter, 101 half-dollar, 110 dollar.
- `coin_ready` output 1: request accepted on `coin_valid & coin_ready`.
- `coin_sensor` input 1: asynchronous exit-chute sensor, high while a coin passes.
- `refill` input 1: one-cycle command that reloads inventory.
- `refill_sel` input 3: coin code to reload.
- `fault_clear` input 1: clears the fault.
- `eject` output 6: one-hot solenoid drive; bit 0 is penny through bit 5 dollar.
- `dispensed` output 1: one-cycle pulse per confirmed coin.
- `underflow` output 1: one-cycle pulse when a request hits an empty denomination.
- `empty` output 6: inventory-zero flag per denomination.
- `fault` output 1: sticky jam flag.

## Operation
- States are IDLE, PULSE, WAIT and FAULT. All outputs are registered.
- IDLE: `coin_ready`=1.
  - Codes 000 and 111 are accepted and discarded, with no pulse output.
  - A valid code for a denomination with `empty` set is accepted and discarded, and `underflow` pulses.
  - Otherwise the code is latched, the retry count is cleared, and the state moves to PULSE.
- PULSE: `eject[sel]`=1 for `PULSE_CYCLES` cycles, then the state moves to WAIT.
- WAIT: `eject`=0 and the timer runs.
  - On a sensor rising edge: inventory[sel] decrements, `dispensed` pulses, and the state returns to IDLE.
  - On timer reaching `TIMEOUT_CYCLES` with retries below `MAX_RETRY`: retries increment and the state returns to PULSE.
  - Otherwise the state moves to FAULT.
- A sensor edge during PULSE ends the pulse at once and completes the coin as in WAIT.
- A sensor edge in IDLE or FAULT is ignored.
- FAULT: `fault`=1, `coin_ready`=0, `eject`=0. `fault_clear` moves the state to IDLE and clears `fault`. The latched coin is dropped.
- `coin_ready`=0 in every state except IDLE.
- `refill` is honoured in any state: inventory[refill_sel] is set to `INV_INIT`. It wins over a same-cycle decrement of the same denomination. Codes 000 and 111 have no effect.
- Inventory never decrements below 0. `empty[i]` = (inventory[i]==0), updated the cycle after the count changes.
- Reset:
  - state IDLE, all inventories `INV_INIT`, retries 0.
  - `coin_ready`=1; `eject`, `dispensed`, `underflow`, `empty` and `fault` all 0.
  - Reset mid-PULSE drops the solenoid the next cycle.

## Timing
- Accept at edge T:
  - `eject` high for cycles T+1 through T+`PULSE_CYCLES`.
  - WAIT begins at T+`PULSE_CYCLES`+1.
- The sensor passes through a 2-flop synchronizer plus an edge detector. `dispensed` rises 3 cycles after the sensor's first high sample. `coin_ready` returns the same cycle as `dispensed`.
- With no sensor response, the worst-case occupancy per coin is (MAX_RETRY+1)·(PULSE_CYCLES+TIMEOUT_CYCLES) cycles, after which `fault` rises.
- A discard (invalid code or empty denomination) keeps `coin_ready` high, so back-to-back accepts proceed at 1 per cycle.
- `underflow` is asserted the cycle after acceptance.

## Structure
- Shared package `coin_pkg` holds:
  - the coin code constants `COIN_NONE` through `COIN_DOLLAR` (the same encoding `coin_summer` and `coin_dispenser` use);
  - a code-to-one-hot function;
  - the hopper state enum.
- Sub-module `sensor_sync_edge`: 2-flop synchronizer plus rising-edge pulse, reset to 0.

## Test plan
- Reset low for 2 cycles → `coin_ready`=1, `eject`=0, `empty`=0, `fault`=0.
- Quarter (100) accepted; sensor high 2 cycles during WAIT →
  - `eject`=6'b001000 for exactly 4 cycles;
  - one `dispensed` pulse;
  - quarter inventory 49.
- Dime accepted, sensor never toggles →
  - 3 pulse bursts separated by 64-cycle waits;
  - `fault`=1, `coin_ready`=0;
  - `fault_clear` restores IDLE with dime inventory still 50.
- 50 pennies dispensed → `empty[0]`=1. A 51st penny request gives `underflow` pulse, no eject, `coin_ready` stays 1. `refill`/001 clears `empty[0]`.
- Codes 000 and 111 presented on consecutive cycles → both accepted, no eject, no pulses.
- Sensor edge in the 2nd PULSE cycle → pulse truncated, `dispensed` pulses. Also refill of the same denomination on the decrement cycle → inventory 50.
